// File: rtl/gshare_bht.sv
// gshare_bht: table of 2-bit saturating counters indexed by PC XOR global
// history (or PC alone in bimodal mode). After reset the table is swept to
// weak-not-taken, one entry per cycle, before requests are accepted.
// Predictions return one cycle after acceptance; updates train the counter
// and, on a mispredict, rebuild the speculative history.
module gshare_bht #(
    parameter int ENTRIES   = 64,
    parameter int HIST_BITS = 6,
    parameter int GSHARE    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 ready,
    input  logic                 pred_valid,
    input  logic [31:0]          pred_pc,
    output logic                 resp_valid,
    output logic                 resp_taken,
    output logic [HIST_BITS-1:0] resp_ghr,
    input  logic                 upd_valid,
    input  logic [31:0]          upd_pc,
    input  logic [HIST_BITS-1:0] upd_ghr,
    input  logic                 upd_taken,
    input  logic                 upd_mispredict
);

    localparam int IDX_BITS = $clog2(ENTRIES);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [1:0] CNT_WEAK_NT = 2'b01;

    logic [0:0]          state_q;
    logic [IDX_BITS-1:0] sweep_q;
    logic [HIST_BITS-1:0] ghr_q;
    logic [1:0]          table_q [ENTRIES];

    logic                pred_fire;
    logic                upd_fire;
    logic [IDX_BITS-1:0] pred_idx;
    logic [IDX_BITS-1:0] upd_idx;
    logic                pred_taken;
    logic [1:0]          upd_cnt_next;
    logic [HIST_BITS-1:0] ghr_shift;
    logic [HIST_BITS-1:0] ghr_recov;
    logic                wr_en;
    logic [IDX_BITS-1:0] wr_idx;
    logic [1:0]          wr_data;

    // Only bits [IDX_BITS+1:2] of a PC select an entry; the rest are
    // deliberately ignored.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc[31:IDX_BITS+2], pred_pc[1:0],
                              upd_pc[31:IDX_BITS+2], upd_pc[1:0]};

    function automatic logic [IDX_BITS-1:0] make_idx(input logic [31:0] pc,
                                                      input logic [HIST_BITS-1:0] hist);
        if (GSHARE != 0) return pc[IDX_BITS+1:2] ^ IDX_BITS'(hist);
        else             return pc[IDX_BITS+1:2];
    endfunction

    function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
        if (up) return (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
        else    return (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
    endfunction

    assign ready     = (state_q == ST_RUN);
    assign pred_fire = ready && pred_valid;
    assign upd_fire  = ready && upd_valid;

    // Index formation, table read, history next-values and the single write port.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        pred_idx     = make_idx(pred_pc, ghr_q);
        upd_idx      = make_idx(upd_pc, upd_ghr);
        pred_taken   = table_q[pred_idx][1];
        upd_cnt_next = sat_step(table_q[upd_idx], upd_taken);
        ghr_shift    = (ghr_q << 1) | HIST_BITS'(pred_taken);
        ghr_recov    = (upd_ghr << 1) | HIST_BITS'(upd_taken);
        wr_en        = 1'b0;
        wr_idx       = sweep_q;
        wr_data      = CNT_WEAK_NT;
        if (rst_n) begin
            if (state_q == ST_INIT) begin
                wr_en = 1'b1;
            end else if (upd_fire) begin
                wr_en   = 1'b1;
                wr_idx  = upd_idx;
                wr_data = upd_cnt_next;
            end
        end
    end

    // Counter table storage; the prediction read above sees the pre-write value.
    always_ff @(posedge clk) begin
        // NOTE: the table has no reset; the INIT sweep establishes its contents instead.
        if (wr_en) table_q[wr_idx] <= wr_data;
    end

    // Init sweep FSM, speculative history and registered prediction response.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            state_q    <= ST_INIT;
            sweep_q    <= '0;
            ghr_q      <= '0;
            resp_valid <= 1'b0;
            resp_taken <= 1'b0;
            resp_ghr   <= '0;
        end else begin
            if (state_q == ST_INIT) begin
                sweep_q <= sweep_q + IDX_BITS'(1);
                if (sweep_q == IDX_BITS'(ENTRIES - 1)) state_q <= ST_RUN;
            end

            resp_valid <= pred_fire;
            if (pred_fire) begin
                resp_taken <= pred_taken;
                resp_ghr   <= ghr_q;
            end

            // Mispredict recovery takes priority over the speculative shift.
            if (upd_fire && upd_mispredict) ghr_q <= ghr_recov;
            else if (pred_fire)             ghr_q <= ghr_shift;
        end
    end

endmodule

// File: tb/tb_gshare_bht.sv
// tb_gshare_bht: directed scenarios plus randomized traffic against a small
// behavioural model; expected responses go into a scoreboard queue and a
// monitor compares them as the DUT presents responses.
module tb_gshare_bht;

    localparam int ENTRIES   = 16;
    localparam int HIST_BITS = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ready;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        resp_valid;
    logic        resp_taken;
    logic [3:0]  resp_ghr;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [3:0]  upd_ghr;
    logic        upd_taken;
    logic        upd_mispredict;

    gshare_bht #(.ENTRIES(ENTRIES), .HIST_BITS(HIST_BITS), .GSHARE(1)) dut (
        .clk(clk), .rst_n(rst_n), .ready(ready),
        .pred_valid(pred_valid), .pred_pc(pred_pc),
        .resp_valid(resp_valid), .resp_taken(resp_taken), .resp_ghr(resp_ghr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
        .upd_taken(upd_taken), .upd_mispredict(upd_mispredict)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       taken;
        bit [3:0] ghr;
        int       due;
    } exp_t;

    exp_t     sb[$];
    int       checks   = 0;
    int       failures = 0;
    int       cyc      = 0;
    int       mcnt[ENTRIES];
    bit [3:0] mghr;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: a response must appear exactly in the cycle its entry is due.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            check("resp_valid", {31'b0, resp_valid}, 32'd1);
            if (resp_valid === 1'b1) begin
                check("resp_taken", {31'b0, resp_taken}, {31'b0, sb[0].taken});
                check("resp_ghr", {28'b0, resp_ghr}, {28'b0, sb[0].ghr});
            end
            void'(sb.pop_front());
        end else if (resp_valid === 1'b1) begin
            check("resp_unexpected", {31'b0, resp_valid}, 32'd0);
        end
    end

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) mcnt[i] = 1;
        mghr = 4'b0;
    endfunction

    // One clock of stimulus; the model is advanced using the spec's rules.
    task automatic do_cycle(input bit pv, input logic [31:0] ppc,
                            input bit uv, input logic [31:0] upc, input bit [3:0] ughr,
                            input bit ut, input bit um);
        int       pidx;
        int       uidx;
        bit       ptaken;
        bit [3:0] next_ghr;
        pred_valid = pv; pred_pc = ppc;
        upd_valid = uv; upd_pc = upc; upd_ghr = ughr;
        upd_taken = ut; upd_mispredict = um;
        next_ghr = mghr;
        if (pv) begin
            pidx   = int'(((ppc >> 2) ^ {28'b0, mghr}) & 32'hF);
            ptaken = (mcnt[pidx] >= 2);
            sb.push_back('{taken: ptaken, ghr: mghr, due: cyc + 1});
            next_ghr = {mghr[2:0], ptaken};
        end
        if (uv) begin
            uidx = int'(((upc >> 2) ^ {28'b0, ughr}) & 32'hF);
            if (ut) mcnt[uidx] = (mcnt[uidx] == 3) ? 3 : mcnt[uidx] + 1;
            else    mcnt[uidx] = (mcnt[uidx] == 0) ? 0 : mcnt[uidx] - 1;
            if (um) next_ghr = {ughr[2:0], ut};
        end
        mghr = next_ghr;
        @(posedge clk); #1;
        pred_valid = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, n, 16);
    endtask

    task automatic rand_phase(input int n);
        for (int i = 0; i < n; i++)
            do_cycle($urandom_range(0, 1) == 1, $urandom,
                     $urandom_range(0, 1) == 1, $urandom, 4'($urandom),
                     $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; pred_valid = 1'b0; pred_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_ghr = '0; upd_taken = 1'b0; upd_mispredict = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'b0, ready}, 32'd0);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_taken", {31'b0, resp_taken}, 32'd0);
        check("rst_resp_ghr", {28'b0, resp_ghr}, 32'd0);
        rst_n = 1'b1;
        wait_ready("init_cycles");

        // Fresh table predicts not-taken.
        do_cycle(1, 32'h0000_1234, 0, 0, 0, 0, 0);
        check("fresh_nt", {31'b0, resp_taken}, 32'd0);

        // Four taken updates on index 0 saturate at strong-taken.
        repeat (4) do_cycle(0, 0, 1, 32'h40, 4'h0, 1, 0);
        do_cycle(1, 32'h40, 0, 0, 0, 0, 0);
        check("sat_taken", {31'b0, resp_taken}, 32'd1);

        // Restore GHR to 0 through a mispredict, then NT,NT,T,T,NT predictions.
        do_cycle(0, 0, 1, 32'h3C, 4'h0, 0, 1);
        do_cycle(1, 32'h04, 0, 0, 0, 0, 0);
        do_cycle(1, 32'h04, 0, 0, 0, 0, 0);
        do_cycle(1, 32'h40, 0, 0, 0, 0, 0);
        do_cycle(1, 32'h04, 0, 0, 0, 0, 0);
        check("hist_t4", {31'b0, resp_taken}, 32'd1);
        do_cycle(1, 32'h14, 0, 0, 0, 0, 0);
        check("hist_ghr_0011", {28'b0, resp_ghr}, 32'h3);

        // Predict together with mispredict recovery: old GHR reported, recovery wins.
        do_cycle(1, 32'h00, 1, 32'h08, 4'h1, 1, 1);
        check("recov_resp_ghr", {28'b0, resp_ghr}, 32'h6);
        do_cycle(1, 32'h1C, 1, 32'h10, 4'h0, 1, 0);
        check("recov_ghr_after", {28'b0, resp_ghr}, 32'h3);
        check("rbw_pre_value", {31'b0, resp_taken}, 32'd0);
        do_cycle(1, 32'h08, 0, 0, 0, 0, 0);
        check("rbw_post_value", {31'b0, resp_taken}, 32'd1);

        rand_phase(300);

        // Reset mid-run with a predict presented on the reset edge.
        rst_n = 1'b0; pred_valid = 1'b1; pred_pc = $urandom;
        @(posedge clk); #1;
        check("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("midrst_ready", {31'b0, ready}, 32'd0);
        rst_n = 1'b1; pred_valid = 1'b0;
        model_reset();
        wait_ready("reinit_cycles");
        for (int i = 0; i < ENTRIES; i++) do_cycle(1, 32'(i) << 2, 0, 0, 0, 0, 0);

        rand_phase(200);
        @(posedge clk); @(negedge clk); #1;
        check("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
